// File: rtl/spi_mosi_miso_if.sv
// rtl/spi_mosi_miso_if.sv - word-side handshake and serial lines of spi_mosi_miso
interface spi_mosi_miso_if #(
    parameter int W = 32
);
    logic [W-1:0] mosi_data;
    logic         mosi_ready;
    logic         transmit_ready;
    logic         mosi_out;
    logic         spi_clk;
    logic         miso_in;
    logic [W-1:0] miso_data;
    logic         miso_dv;
    logic         receive_ready;

    modport slave (
        input  mosi_data, mosi_ready, miso_in,
        output transmit_ready, receive_ready, mosi_out, spi_clk, miso_data, miso_dv
    );

    modport master (
        output mosi_data, mosi_ready, miso_in,
        input  transmit_ready, receive_ready, mosi_out, spi_clk, miso_data, miso_dv
    );
endinterface

// File: rtl/spi_mosi_miso.sv
// rtl/spi_mosi_miso.sv - full-duplex SPI word shifter, mode 0, MSB first; SPI_LOOPBACK_EN feeds mosi_out back into the receiver
module spi_mosi_miso #(
    parameter int W    = 32,
    parameter int HALF = 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_mosi_miso_if.slave  bus
);
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW = $clog2(W);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  tx_q, rx_q, miso_data_q;
    logic [HW-1:0] hcnt_q;
    logic [BW-1:0] bcnt_q;
    logic          spi_clk_q, mosi_out_q, miso_dv_q;
    logic          accept, half_done, rise, fall, last, sample;

    assign accept    = (state_q == IDLE) && bus.mosi_ready;
    assign half_done = (state_q == BUSY) && (hcnt_q == HW'(HALF - 1));
    assign rise      = half_done && !spi_clk_q;
    assign fall      = half_done && spi_clk_q;
    assign last      = fall && (bcnt_q == BW'(W - 1));

`ifdef SPI_LOOPBACK_EN
    assign sample = mosi_out_q;
`else
    assign sample = bus.miso_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.transmit_ready = (state_q == IDLE);
        bus.receive_ready  = (state_q == IDLE);
        bus.spi_clk        = spi_clk_q;
        bus.mosi_out       = mosi_out_q;
        bus.miso_data      = miso_data_q;
        bus.miso_dv        = miso_dv_q;
    end

    // spi_clk toggles every HALF cycles; odd toggles are rising (sample), even are falling (shift out)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q        <= '0;
            rx_q        <= '0;
            miso_data_q <= '0;
            hcnt_q      <= '0;
            bcnt_q      <= '0;
            spi_clk_q   <= 1'b0;
            mosi_out_q  <= 1'b0;
            miso_dv_q   <= 1'b0;
        end else begin
            miso_dv_q <= 1'b0;
            if (accept) begin
                tx_q       <= bus.mosi_data;
                mosi_out_q <= bus.mosi_data[W-1];
                rx_q       <= '0;
                hcnt_q     <= '0;
                bcnt_q     <= '0;
                spi_clk_q  <= 1'b0;
            end else if (state_q == BUSY) begin
                if (half_done) begin
                    hcnt_q    <= '0;
                    spi_clk_q <= ~spi_clk_q;
                end else begin
                    hcnt_q <= hcnt_q + 1'b1;
                end
                if (rise) rx_q <= {rx_q[W-2:0], sample};
                if (fall) begin
                    if (last) begin
                        miso_data_q <= rx_q;
                        miso_dv_q   <= 1'b1;
                    end else begin
                        tx_q       <= tx_q << 1;
                        mosi_out_q <= tx_q[W-2];
                        bcnt_q     <= bcnt_q + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_mosi_miso.sv
// tb/tb_spi_mosi_miso.sv - randomized directed bench for spi_mosi_miso at W=32/HALF=1 and W=8/HALF=3
module tb_spi_mosi_miso;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cmps = 0;
    int   errs = 0;
    logic [31:0] exp_last [2];

    always #5 clk = ~clk;

    spi_mosi_miso_if #(.W(32)) bus_a ();
    spi_mosi_miso_if #(.W(8))  bus_b ();

    spi_mosi_miso #(.W(32), .HALF(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    spi_mosi_miso #(.W(8),  .HALF(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    // {transmit_ready, receive_ready, spi_clk, mosi_out, miso_dv}
    function automatic logic [4:0] obs_status(int which);
        if (which == 0)
            return {bus_a.transmit_ready, bus_a.receive_ready, bus_a.spi_clk, bus_a.mosi_out, bus_a.miso_dv};
        return {bus_b.transmit_ready, bus_b.receive_ready, bus_b.spi_clk, bus_b.mosi_out, bus_b.miso_dv};
    endfunction

    function automatic logic [31:0] obs_data(int which);
        if (which == 0) return bus_a.miso_data;
        return {24'h0, bus_b.miso_data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic rdy, input logic [31:0] data, input logic miso);
        bus_a.mosi_ready = (which == 0) ? rdy  : 1'b0;
        bus_a.mosi_data  = (which == 0) ? data : 32'h0;
        bus_a.miso_in    = (which == 0) ? miso : 1'b0;
        bus_b.mosi_ready = (which == 1) ? rdy  : 1'b0;
        bus_b.mosi_data  = (which == 1) ? data[7:0] : 8'h0;
        bus_b.miso_in    = (which == 1) ? miso : 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_status_a"}, {27'h0, obs_status(0)}, 32'h18);
        chk({tag, "_data_a"},   obs_data(0), 32'h0);
        chk({tag, "_status_b"}, {27'h0, obs_status(1)}, 32'h18);
        chk({tag, "_data_b"},   obs_data(1), 32'h0);
    endtask

    // One transaction, timed from t=0 at the accept edge; strobe_at/abort_at of 0 disable those events
    task automatic run_txn(input int which, input logic [31:0] tx, input logic [31:0] rx,
                           input int strobe_at, input int abort_at, input int idle_after);
        int w, h, len, k, j;
        logic [31:0] exp_rx;
        logic sclk, mo, done;
        w   = (which == 0) ? 32 : 8;
        h   = (which == 0) ? 1 : 3;
        len = 2 * w * h;
`ifdef SPI_LOOPBACK_EN
        exp_rx = tx;
`else
        exp_rx = rx;
`endif
        if (w < 32) exp_rx = exp_rx & ((32'h1 << w) - 1);

        drive(which, 1'b1, tx, 1'b0);
        @(posedge clk); #1;
        chk("accept_status", {27'h0, obs_status(which)}, {27'h0, 2'b00, 1'b0, tx[w-1], 1'b0});
        for (int t = 1; t <= len; t++) begin
            k = (t - 1) / (2 * h);
            drive(which, t == strobe_at, (t == strobe_at) ? 32'h12345678 : $urandom, rx[w-1-k]);
            @(posedge clk); #1;
            if (t == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_values("abort");
                exp_last[0] = 32'h0;
                exp_last[1] = 32'h0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            sclk = ((t / h) % 2) == 1;
            j    = t / (2 * h);
            if (j > w - 1) j = w - 1;
            mo   = tx[w-1-j];
            done = (t == len);
            chk("busy_status", {27'h0, obs_status(which)}, {27'h0, done, done, sclk, mo, done});
            chk("busy_data", obs_data(which), done ? exp_rx : exp_last[which]);
        end
        exp_last[which] = exp_rx;
        for (int i = 0; i < idle_after; i++) begin
            drive(which, 1'b0, $urandom, $urandom);
            @(posedge clk); #1;
            chk("idle_status", {27'h0, obs_status(which)}, {27'h0, 2'b11, 1'b0, tx[0], 1'b0});
            chk("idle_data", obs_data(which), exp_rx);
        end
    endtask

    initial begin
        exp_last[0] = 32'h0;
        exp_last[1] = 32'h0;
        drive(0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("reset_release");

        run_txn(0, 32'hA5A5F00F, $urandom, 0, 0, 0);
        run_txn(0, 32'h00000000, 32'hFFFFFFFF, 0, 0, 2);
        run_txn(0, $urandom, $urandom, 10, 0, 3);
        run_txn(0, $urandom, $urandom, 0, 20, 0);
        run_txn(0, $urandom, $urandom, 0, 0, 1);

        run_txn(1, 32'h3C, $urandom, 0, 0, 1);
        for (int n = 0; n < 4; n++) run_txn(1, $urandom, $urandom, 0, 0, 0);
        run_txn(1, $urandom, $urandom, 7, 0, 2);
        for (int n = 0; n < 4; n++) run_txn(0, $urandom, $urandom, 0, 0, n % 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/spi_mosi_miso.md
SPI_MOSI_MISO -- requirements
Module: spi_mosi_miso

Interface
REQ-001 SHALL provide parameter W, default 32: word width in bits (matches CPU word); legal range 2..32.
REQ-002 SHALL provide parameter HALF, default 1: clk cycles per spi_clk half-period; legal range >=1.
REQ-003 SHALL provide port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1: reset; asynchronous, active-low.
REQ-005 SHALL provide port mosi_data  input  W: word to transmit.
REQ-006 SHALL provide port mosi_ready  input  1: start strobe; word on mosi_data is valid this cycle.
REQ-007 SHALL provide port transmit_ready  output  1: high when idle and able to accept a word.
REQ-008 SHALL provide port mosi_out  output  1: serial data to the device.
REQ-009 SHALL provide port spi_clk  output  1: serial clock; idles low.
REQ-010 SHALL provide port miso_in  input  1: serial data from the device.
REQ-011 SHALL provide port miso_data  output  W: last fully received word.
REQ-012 SHALL provide port miso_dv  output  1: one-cycle pulse when miso_data is updated.
REQ-013 SHALL provide port receive_ready  output  1: high when idle; always equal to transmit_ready.

Function
REQ-014 Two states SHALL exist: IDLE and BUSY; IDLE->BUSY on a clk edge with mosi_ready=1 and transmit_ready=1 (the "accept edge", t=0).
REQ-015 At the accept edge mosi_data SHALL be latched; mosi_ready while BUSY SHALL be ignored; mosi_data SHALL be don't-care after t=0.
REQ-016 From t=0, transmit_ready and receive_ready SHALL be 0 and mosi_out SHALL equal latched bit W-1 (MSB first).
REQ-017 The k-th spi_clk rising edge (k=1..W) SHALL occur at clk edge t=(2k-1)*HALF; the k-th falling edge at t=2k*HALF.
REQ-018 miso_in SHALL be sampled at each spi_clk rising edge and shifted in MSB first.
REQ-019 At each falling edge k<W, mosi_out SHALL advance to latched bit W-1-k.
REQ-020 At t=2*W*HALF (last falling edge), miso_data SHALL take the W sampled bits, miso_dv SHALL be 1 for exactly that one cycle, and the block SHALL return to IDLE with both ready outputs at 1.
REQ-021 A new word MAY be accepted on the clk edge immediately following the return to IDLE (back-to-back; no idle gap required).
REQ-022 In IDLE: spi_clk=0, mosi_out holds its last value, and miso_data holds its value.
REQ-023 Transaction length SHALL be 2*W*HALF clk cycles (64 at defaults).

Reset
REQ-024 While rst=0: transmit_ready=1, receive_ready=1, spi_clk=0, mosi_out=0, miso_data=0, miso_dv=0, state=IDLE, shift registers=0.
REQ-025 rst asserted mid-transaction SHALL abort it immediately: no miso_dv pulse, miso_data=0.
REQ-026 The first accept SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-027 Macro SPI_LOOPBACK_EN: when defined, the receive shifter SHALL sample mosi_out in place of miso_in and miso_in SHALL be ignored; when undefined, miso_in SHALL be sampled as per REQ-018.

Verification
REQ-028 Reset release -> transmit_ready=1, receive_ready=1, spi_clk=0, mosi_out=0, miso_data=0, miso_dv=0.
REQ-029 Defaults with SPI_LOOPBACK_EN defined: send 0xA5A5F00F -> 32 spi_clk pulses; miso_dv pulse at t=64; miso_data=0xA5A5F00F; ready outputs return high at t=64.
REQ-030 Loopback disabled, miso_in held at 1: send 0x00000000 -> mosi_out=0 throughout the transaction; miso_data=0xFFFFFFFF.
REQ-031 Strobe mosi_ready=1 with 0x12345678 at t=10 during a transaction -> ignored; the first word completes unchanged and no second transaction starts.
REQ-032 Assert rst at t=20 of a transaction -> immediate abort; no miso_dv pulse; all outputs at reset values.
REQ-033 HALF=3, W=8, loopback, send 0x3C -> spi_clk high/low 3 cycles each; miso_data=0x3C, with the miso_dv pulse at t=48.
